smiley_collision_detector: RTL
==============================

# smiley_collision_detector

Per-frame collision detector that sits directly downstream of the smiley drawing stage and of the border, flipper and obstacle drawing stages. It counts pixel overlaps between `draw_smiley` and each other object during one VGA frame and filters out glitches with a minimum-overlap threshold. At the next `startOfFrame` it emits single-cycle collision pulses. These pulses drive the smiley controller's border, flipper and obstacle collision inputs. A per-source cooldown suppresses repeated pulses while the smiley stays embedded in an object.

## Interface
Parameters:
- `MIN_OVERLAP`, 4: overlapping pixels per frame required to declare a collision (1..255).
- `COOLDOWN_FRAMES`, 3: frames a source stays suppressed after it pulses (0..15; 0 disables the cooldown).

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `startOfFrame`  in  1  one-cycle frame-start strobe.
- `pause`  in  1  game paused.
- `draw_smiley`  in  1  smiley pixel active.
- `draw_border_top`, `draw_border_left`, `draw_border_right`  in  1 each  border pixels active.
- `draw_flipper`  in  1  flipper pixel active.
- `draw_obstacle`  in  1  obstacle pixel active.
- `collisionSmileyBorderTop`, `collisionSmileyBorderLeft`, `collisionSmileyBorderRight`, `collisionSmileyFlipper`, `collisionSmileyObstacle`  out  1 each  single-cycle collision pulses.
- `frameHitMask`  out  5  last frame's raw hits. Bit order: {obstacle, flipper, right, left, top}.

All `draw_*` inputs are pixel-aligned with each other (same pipeline depth).

## Operation
- There are five independent channels, indexed 0..4 in `frameHitMask` order. Each channel has the following state:
  - `ovl_cnt`: 8-bit saturating counter.
  - `cool_cnt`: 4-bit counter.
  - `pend`: a pending flag.
- In every cycle, channel i has an overlap when `draw_smiley && draw_i`.
- In a cycle without `startOfFrame`:
  - If channel i overlaps, `ovl_cnt[i]` increments and saturates at 255.
- In a `startOfFrame` cycle:
  - The channel's hit is `hit_i = (ovl_cnt[i] >= MIN_OVERLAP)`.
  - `frameHitMask[i]` is loaded with `hit_i`.
  - `ovl_cnt[i]` is loaded with 1 if the current cycle overlaps, else 0. The strobe pixel belongs to the new frame.
  - Channel cases:
    - `hit_i`, `cool_cnt[i]==0` and `!pause`: set `pend[i]` and load `cool_cnt[i]` with `COOLDOWN_FRAMES`.
    - `hit_i` and `cool_cnt[i]!=0` and `!pause`: no pulse. The cooldown reloads to `COOLDOWN_FRAMES` (stays suppressed while embedded).
    - `!hit_i` and `!pause`: `cool_cnt[i]` decrements if nonzero.
    - `pause`: no pend and no cooldown change. Counting and `frameHitMask` still update.
- Pulse output: collision output i equals `pend[i]`, registered. `pend[i]` clears on the following cycle, so each pulse is exactly one cycle wide.
- Simultaneous hits on several channels pulse together in the same cycle. There is no priority between channels.
- Overlaps on `draw_*` are ignored while `draw_smiley` is low.

## Timing
- Reset values (next edge with `reset` high):
  - all outputs 0;
  - `ovl_cnt`, `cool_cnt` and `pend` all 0.
- Reset has priority over `startOfFrame`.
- Reset mid-frame discards the partial counts. The first frame after reset is therefore partial, and it may miss a collision.
- Latency: a collision pulse is high in cycle N+1, where N is the `startOfFrame` cycle that closes the hit frame. `frameHitMask` is valid from cycle N+1.
- Back-to-back `startOfFrame` (consecutive cycles) is legal:
  - each strobe evaluates the count accumulated so far;
  - the pulse rule still holds, because a pulse requires `cool_cnt==0`.
- With `COOLDOWN_FRAMES=0`, a channel pulses on every frame that hits.
- `MIN_OVERLAP` of at most 255 guarantees that saturation never hides a hit.

## Structure
- Shared package `pinball_pkg` holds:
  - `CH_TOP=0`, `CH_LEFT=1`, `CH_RIGHT=2`, `CH_FLIPPER=3`, `CH_OBSTACLE=4`, `NUM_CH=5`;
  - the `ovl_cnt_t` (8-bit) and `cool_cnt_t` (4-bit) typedefs.
- One sub-module, `collision_channel`, instantiated 5 times. Its ports:
  - inputs: `clk`, `reset`, `startOfFrame`, `pause`, `overlap`;
  - outputs: `pulse`, `hit`.
  - It also takes both parameters.
- The top level only ANDs `draw_smiley` with each `draw_*` input and maps the channels to the output ports.

## Test plan
- **Threshold:** 3 overlapping top-border pixels in a frame, then `startOfFrame` → no pulse and `frameHitMask[0]=0`. Then 4 pixels → `collisionSmileyBorderTop` high for exactly 1 cycle, at N+1.
- **Cooldown:** flipper overlap of 10 pixels in 6 consecutive frames with `COOLDOWN_FRAMES=3` → exactly 1 pulse, after frame 1. Then 3 clean frames followed by 1 hit frame → a second pulse.
- **Simultaneous:** left and obstacle each overlap 5 pixels in the same frame → both pulses high in the same cycle, `frameHitMask=5'b10010`.
- **Pause:** hit frame with `pause=1` → no pulse, `frameHitMask` bit set, `cool_cnt` unchanged. Next hit frame with `pause=0` → pulse.
- **Strobe boundary:** overlap asserted only in the `startOfFrame` cycle, with `MIN_OVERLAP=1` → no pulse at that strobe, pulse after the next strobe.
- **Reset mid-frame:** 100 overlap pixels, `reset` for 1 cycle, then `startOfFrame` → no pulse, all outputs 0.

Source files
------------

// File: rtl/pinball_pkg.sv
// Shared pinball definitions: collision channel indices and counter types
// used by the smiley collision detector.
package pinball_pkg;

    localparam int CH_TOP      = 0;
    localparam int CH_LEFT     = 1;
    localparam int CH_RIGHT    = 2;
    localparam int CH_FLIPPER  = 3;
    localparam int CH_OBSTACLE = 4;
    localparam int NUM_CH      = 5;

    typedef logic [7:0] ovl_cnt_t;
    typedef logic [3:0] cool_cnt_t;

endpackage

// File: rtl/collision_channel.sv
// One collision channel: counts smiley overlaps over a frame, thresholds the
// count at startOfFrame and emits a one-cycle pulse gated by a cooldown.
module collision_channel
    import pinball_pkg::*;
#(
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic pause,
    input  logic overlap,
    output logic pulse,
    output logic hit
);

    localparam ovl_cnt_t  MinOverlap  = ovl_cnt_t'(MIN_OVERLAP);
    localparam cool_cnt_t CoolReload  = cool_cnt_t'(COOLDOWN_FRAMES);
    localparam ovl_cnt_t  OvlMax      = '1;

    ovl_cnt_t  ovlCnt;
    cool_cnt_t coolCnt;
    logic      pend;
    logic      hitReg;
    logic      frameHit;

    assign frameHit = (ovlCnt >= MinOverlap);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge value of ovlCnt/coolCnt, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovlCnt  <= '0;
            coolCnt <= '0;
            pend    <= 1'b0;
            hitReg  <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (startOfFrame) begin
                // The strobe pixel already belongs to the new frame.
                ovlCnt <= overlap ? ovl_cnt_t'(1) : ovl_cnt_t'(0);
                hitReg <= frameHit;
                if (!pause) begin
                    if (frameHit) begin
                        coolCnt <= CoolReload;
                        if (coolCnt == '0) pend <= 1'b1;
                    end else if (coolCnt != '0) begin
                        coolCnt <= coolCnt - cool_cnt_t'(1);
                    end
                end
            end else if (overlap && ovlCnt != OvlMax) begin
                ovlCnt <= ovlCnt + ovl_cnt_t'(1);
            end
        end
    end

    assign pulse = pend;
    assign hit   = hitReg;

endmodule

// File: rtl/smiley_collision_detector.sv
// Per-frame smiley collision detector: gates each object's draw signal with
// the smiley pixel and feeds one collision channel per object.
module smiley_collision_detector
    import pinball_pkg::*;
#(
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic                pause,
    input  logic                draw_smiley,
    input  logic                draw_border_top,
    input  logic                draw_border_left,
    input  logic                draw_border_right,
    input  logic                draw_flipper,
    input  logic                draw_obstacle,
    output logic                collisionSmileyBorderTop,
    output logic                collisionSmileyBorderLeft,
    output logic                collisionSmileyBorderRight,
    output logic                collisionSmileyFlipper,
    output logic                collisionSmileyObstacle,
    output logic [NUM_CH-1:0]   frameHitMask
);

    logic [NUM_CH-1:0] drawObj;
    logic [NUM_CH-1:0] overlap;
    logic [NUM_CH-1:0] pulse;

    assign drawObj = {draw_obstacle, draw_flipper, draw_border_right,
                      draw_border_left, draw_border_top};
    assign overlap = drawObj & {NUM_CH{draw_smiley}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        collision_channel #(
            .MIN_OVERLAP     (MIN_OVERLAP),
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .startOfFrame (startOfFrame),
            .pause        (pause),
            .overlap      (overlap[i]),
            .pulse        (pulse[i]),
            .hit          (frameHitMask[i])
        );
    end

    assign collisionSmileyBorderTop   = pulse[CH_TOP];
    assign collisionSmileyBorderLeft  = pulse[CH_LEFT];
    assign collisionSmileyBorderRight = pulse[CH_RIGHT];
    assign collisionSmileyFlipper     = pulse[CH_FLIPPER];
    assign collisionSmileyObstacle    = pulse[CH_OBSTACLE];

endmodule
